// File: rtl/virtio_available_ring_request_generator_pkg.sv
// Types shared by the virtio available ring request generator and the
// available ring monitor downstream of it.
package virtio_available_ring_pkg;

   // Request kinds carried on tid between the ring engines.
   typedef enum logic [1:0] {
      REQUEST_NONE       = 2'd0,
      REQUEST_READ_RING  = 2'd1,
      REQUEST_READ_DESC  = 2'd2,
      REQUEST_WRITE_USED = 2'd3
   } request_type_t;

   // One ring read: starting slot and number of consecutive indexes.
   typedef struct packed {
      logic [15:0] offset;
      logic [15:0] length;
   } request_t;

   // Generator FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ISSUE = 2'd2
   } generator_state_t;

   localparam int REQUEST_TYPE_W = $bits(request_type_t);
   localparam int REQUEST_W      = $bits(request_t);

   // Largest request starting at 'slot' that neither crosses the ring end
   // nor a max_idx-aligned boundary, and never exceeds what is pending.
   // max_idx must be a power of 2.
   function automatic logic [15:0] chunk_len(input logic [15:0] pending,
                                             input logic [15:0] slot,
                                             input logic [15:0] queue_size,
                                             input logic [15:0] max_idx);
      logic [15:0] align_room;
      logic [15:0] ring_room;
      logic [15:0] len;
      align_room = max_idx - (slot & (max_idx - 16'd1));
      ring_room  = queue_size - slot;
      len        = pending;
      if (align_room < len) len = align_room;
      if (ring_room < len)  len = ring_room;
      return len;
   endfunction

endpackage

// File: rtl/virtio_available_ring_request_generator_if.sv
// AXI4-Stream style link used for both the avail->idx input and the
// request output of the generator.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and
// tready are both high. Once tvalid is raised, tvalid, tdata, tlast and
// tid hold steady until that transfer; tready may change freely.
interface virtio_available_ring_request_generator_if #(
   parameter int DATA_W = 16,
   parameter int ID_W   = 2
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic [ID_W-1:0]   tid;

   modport master (output tvalid, output tdata, output tlast, output tid, input tready);
   modport slave  (input tvalid, input tdata, input tlast, input tid, output tready);
endinterface

// File: rtl/virtio_available_ring_request_generator.sv
// Turns new avail->idx values for one virtqueue into REQUEST_READ_RING
// requests, each aligned and wrap-free and at most MAX_DESCRIPTOR_INDEXES
// long, for the available ring monitor downstream.
module virtio_available_ring_request_generator
   import virtio_available_ring_pkg::*;
#(
   parameter int MAX_DESCRIPTOR_INDEXES = 4
) (
   input  logic                                              aclk,
   input  logic                                              areset,
   input  logic                                              enable,
   input  logic                                              clear,
   input  logic [15:0]                                       queue_size,
   virtio_available_ring_request_generator_if.slave          rx,
   virtio_available_ring_request_generator_if.master         tx,
   output logic                                              error,
   output generator_state_t                                  o_dbg_state,
   output logic [15:0]                                       o_dbg_last_idx,
   output logic [15:0]                                       o_dbg_target_idx
);

   if (MAX_DESCRIPTOR_INDEXES < 1 || MAX_DESCRIPTOR_INDEXES > 32768 ||
       (MAX_DESCRIPTOR_INDEXES & (MAX_DESCRIPTOR_INDEXES - 1)) != 0) begin : g_drc_max
      $error("MAX_DESCRIPTOR_INDEXES must be a power of 2 in 1..32768");
   end

   localparam logic [15:0] MAX_IDX = 16'(MAX_DESCRIPTOR_INDEXES);

   generator_state_t r_state;
   generator_state_t w_state_nxt;

   logic [15:0] r_last_idx;
   logic [15:0] r_target_idx;
   logic        r_clear_pend;
   logic        r_tx_valid;
   request_t    r_tx_data;
   logic        r_tx_last;
   logic        r_rx_ready;
   logic        r_error;

   logic [15:0] w_last_nxt;
   logic [15:0] w_target_nxt;
   logic        w_clear_pend_nxt;
   logic        w_tx_valid_nxt;
   request_t    w_tx_data_nxt;
   logic        w_tx_last_nxt;
   logic        w_error_nxt;

   logic        w_rx_hs;
   logic        w_tx_hs;
   logic        w_clear_now;
   logic [15:0] w_base;
   logic [15:0] w_pending;
   logic [15:0] w_slot;
   logic [15:0] w_chunk;
   logic        w_invalid;

   assign w_rx_hs     = rx.tvalid & r_rx_ready;
   assign w_tx_hs     = r_tx_valid & tx.tready;
   // A clear seen during a burst waits for the in-flight beat to transfer.
   assign w_clear_now = clear | r_clear_pend;

   // In ISSUE the next chunk starts after the beat being handed over, so
   // the chunk math runs from the advanced index in that state.
   assign w_base    = (r_state == ISSUE) ? (r_last_idx + r_tx_data.length) : r_last_idx;
   assign w_pending = r_target_idx - w_base;
   assign w_slot    = w_base & (queue_size - 16'd1);
   assign w_chunk   = chunk_len(w_pending, w_slot, queue_size, MAX_IDX);
   assign w_invalid = (w_pending > queue_size);

   // State register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state selection.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            // Level test on enable also covers enable bouncing mid-burst.
            if (clear)                                w_state_nxt = IDLE;
            else if (w_rx_hs)                         w_state_nxt = CHECK;
            else if (enable && (w_pending != 16'd0))  w_state_nxt = CHECK;
         end
         CHECK: begin
            if (clear || w_invalid || (w_pending == 16'd0) || !enable) w_state_nxt = IDLE;
            else                                                       w_state_nxt = ISSUE;
         end
         ISSUE: begin
            if (w_tx_hs && (r_tx_last || !enable || w_clear_now)) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Next values for index tracking, the request beat and the error pulse.
   always_comb begin
      w_last_nxt       = r_last_idx;
      w_target_nxt     = r_target_idx;
      w_clear_pend_nxt = r_clear_pend;
      w_tx_valid_nxt   = r_tx_valid;
      w_tx_data_nxt    = r_tx_data;
      w_tx_last_nxt    = r_tx_last;
      w_error_nxt      = 1'b0;
      case (r_state)
         IDLE: begin
            if (clear) begin
               w_last_nxt   = 16'd0;
               w_target_nxt = 16'd0;
            end else if (w_rx_hs) begin
               w_target_nxt = rx.tdata[15:0];
            end
         end
         CHECK: begin
            if (clear) begin
               w_last_nxt   = 16'd0;
               w_target_nxt = 16'd0;
            end else if (w_invalid) begin
               // The driver claimed more entries than the ring holds: drop it.
               w_error_nxt  = 1'b1;
               w_target_nxt = r_last_idx;
            end else if (enable && (w_pending != 16'd0)) begin
               w_tx_valid_nxt       = 1'b1;
               w_tx_data_nxt.offset = w_slot;
               w_tx_data_nxt.length = w_chunk;
               w_tx_last_nxt        = (w_chunk == w_pending);
            end
         end
         ISSUE: begin
            if (clear) w_clear_pend_nxt = 1'b1;
            if (w_tx_hs) begin
               w_last_nxt = w_base;
               if (w_clear_now) begin
                  w_last_nxt       = 16'd0;
                  w_target_nxt     = 16'd0;
                  w_clear_pend_nxt = 1'b0;
                  w_tx_valid_nxt   = 1'b0;
               end else if (r_tx_last || !enable) begin
                  w_tx_valid_nxt = 1'b0;
               end else begin
                  w_tx_data_nxt.offset = w_slot;
                  w_tx_data_nxt.length = w_chunk;
                  w_tx_last_nxt        = (w_chunk == w_pending);
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and registered handshake/error outputs.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_last_idx   <= 16'd0;
         r_target_idx <= 16'd0;
         r_clear_pend <= 1'b0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= '0;
         r_tx_last    <= 1'b0;
         r_rx_ready   <= 1'b1;
         r_error      <= 1'b0;
      end else begin
         r_last_idx   <= w_last_nxt;
         r_target_idx <= w_target_nxt;
         r_clear_pend <= w_clear_pend_nxt;
         r_tx_valid   <= w_tx_valid_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_tx_last    <= w_tx_last_nxt;
         r_rx_ready   <= (w_state_nxt == IDLE);
         r_error      <= w_error_nxt;
      end
   end

   assign rx.tready        = r_rx_ready;
   assign tx.tvalid        = r_tx_valid;
   assign tx.tdata         = r_tx_data;
   assign tx.tlast         = r_tx_last;
   assign tx.tid           = REQUEST_READ_RING;
   assign error            = r_error;
   assign o_dbg_state      = r_state;
   assign o_dbg_last_idx   = r_last_idx;
   assign o_dbg_target_idx = r_target_idx;

endmodule

// File: tb/tb_virtio_available_ring_request_generator.sv
// Bench for the available ring request generator: directed scenarios then
// randomized updates, checked against a chunking model of the ring rules.
module tb_virtio_available_ring_request_generator;
   import virtio_available_ring_pkg::*;

   localparam int MAX = 4;

   logic             aclk;
   logic             areset;
   logic             enable;
   logic             clear;
   logic [15:0]      queue_size;
   logic             error;
   generator_state_t dbg_state;
   logic [15:0]      dbg_last;
   logic [15:0]      dbg_target;

   virtio_available_ring_request_generator_if #(.DATA_W(16), .ID_W(REQUEST_TYPE_W)) rx_if ();
   virtio_available_ring_request_generator_if #(.DATA_W(REQUEST_W), .ID_W(REQUEST_TYPE_W)) tx_if ();

   virtio_available_ring_request_generator #(.MAX_DESCRIPTOR_INDEXES(MAX)) dut (
      .aclk             (aclk),
      .areset           (areset),
      .enable           (enable),
      .clear            (clear),
      .queue_size       (queue_size),
      .rx               (rx_if),
      .tx               (tx_if),
      .error            (error),
      .o_dbg_state      (dbg_state),
      .o_dbg_last_idx   (dbg_last),
      .o_dbg_target_idx (dbg_target)
   );

   // ---------------- clock / reset ----------------
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          err_cycles = 0;
   int          exp_err_cycles = 0;
   int          n_beats = 0;
   int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
   logic [32:0] exp_q[$];       // {tlast, offset, length}
   int          beat_cyc_q[$];
   logic [15:0] m_last = 16'd0;
   logic [15:0] m_target = 16'd0;
   int          m_q = 16;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // tx.tready driver: changes just after the rising edge.
   initial begin
      tx_if.tready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            0:       tx_if.tready = 1'b1;
            1:       tx_if.tready = ($urandom_range(0, 3) != 0);
            default: tx_if.tready = 1'b0;
         endcase
      end
   end

   // Monitor: values at the falling edge are what the next rising edge sees.
   always @(negedge aclk) begin
      if (!areset) begin
         if (error) err_cycles++;
         if (tx_if.tvalid && tx_if.tready) begin
            n_beats++;
            beat_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $error("FAIL unexpected_beat: observed %0h expected no beat", {tx_if.tlast, tx_if.tdata});
            end else begin
               check("tx_beat", {tx_if.tlast, tx_if.tdata}, exp_q.pop_front());
               check("tx_tid", tx_if.tid, REQUEST_READ_RING);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic model_drain();
      int p;
      int slot;
      int c;
      p = int'(16'(m_target - m_last));
      while (p != 0) begin
         slot = int'(m_last) % m_q;
         c = p;
         if (MAX - (slot % MAX) < c) c = MAX - (slot % MAX);
         if (m_q - slot < c)         c = m_q - slot;
         exp_q.push_back({(c == p), 16'(slot), 16'(c)});
         m_last = m_last + 16'(c);
         p = p - c;
      end
   endtask

   task automatic model_update(input logic [15:0] idx);
      logic [15:0] p;
      p = idx - m_last;
      if (int'(p) > m_q) begin
         exp_err_cycles++;
         m_target = m_last;
      end else begin
         m_target = idx;
         if (enable) model_drain();
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_update(input logic [15:0] idx);
      int t;
      t = 0;
      @(negedge aclk);
      while (!rx_if.tready && t < 200) begin
         @(negedge aclk);
         t++;
      end
      check("rx_ready_timeout", (t < 200), 1);
      rx_if.tdata  = idx;
      rx_if.tvalid = 1'b1;
      @(posedge aclk);
      #1;
      rx_if.tvalid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      while (t < budget) begin
         @(negedge aclk);
         t++;
         if (exp_q.size() == 0 && dbg_state == IDLE) break;
      end
      check("drain_timeout", (t < budget), 1);
      repeat (2) @(negedge aclk);
      check("exp_left", exp_q.size(), 0);
      check("error_cycles", err_cycles, exp_err_cycles);
      check("last_idx", dbg_last, m_last);
      check("target_idx", dbg_target, m_target);
   endtask

   task automatic update(input logic [15:0] idx);
      model_update(idx);
      send_update(idx);
      wait_done(20000);
   endtask

   task automatic set_qsize(input int q);
      @(negedge aclk);
      enable = 1'b0;
      repeat (2) @(negedge aclk);
      queue_size = 16'(q);
      m_q = q;
      @(negedge aclk);
      enable = 1'b1;
      repeat (2) @(negedge aclk);
   endtask

   task automatic pulse_clear();
      @(negedge aclk);
      clear = 1'b1;
      @(negedge aclk);
      clear = 1'b0;
      m_last   = 16'd0;
      m_target = 16'd0;
      repeat (2) @(negedge aclk);
      check("clear_last", dbg_last, 16'd0);
      check("clear_target", dbg_target, 16'd0);
   endtask

   task automatic wait_tvalid(input string tag);
      int t;
      t = 0;
      while (!tx_if.tvalid && t < 20) begin
         @(negedge aclk);
         t++;
      end
      check(tag, tx_if.tvalid, 1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      areset       = 1'b1;
      enable       = 1'b0;
      clear        = 1'b0;
      queue_size   = 16'd16;
      rx_if.tvalid = 1'b0;
      rx_if.tdata  = 16'd0;
      rx_if.tlast  = 1'b0;
      rx_if.tid    = '0;

      // Reset values.
      repeat (3) @(negedge aclk);
      check("rst_tvalid", tx_if.tvalid, 0);
      check("rst_tlast", tx_if.tlast, 0);
      check("rst_tdata", tx_if.tdata, 0);
      check("rst_tid", tx_if.tid, REQUEST_READ_RING);
      check("rst_rx_ready", rx_if.tready, 1);
      check("rst_error", error, 0);
      check("rst_last", dbg_last, 0);
      check("rst_target", dbg_target, 0);
      check("rst_state", dbg_state, IDLE);
      areset = 1'b0;
      set_qsize(16);

      // Aligned run with latency and back-to-back throughput.
      beat_cyc_q.delete();
      model_update(16'd6);
      send_update(16'd6);
      @(negedge aclk);
      check("lat_state_check", dbg_state, CHECK);
      check("lat_n1_tvalid", tx_if.tvalid, 0);
      @(negedge aclk);
      check("lat_n2_tvalid", tx_if.tvalid, 1);
      wait_done(100);
      check("aligned_beats", beat_cyc_q.size(), 2);
      if (beat_cyc_q.size() == 2) check("throughput", beat_cyc_q[1] - beat_cyc_q[0], 1);

      // Misaligned run.
      update(16'd12);

      // Ring wrap with queue_size 8.
      set_qsize(8);
      update(16'd14);
      update(16'd19);

      // Clear while idle, then an invalid update.
      pulse_clear();
      begin
         int nb0;
         nb0 = n_beats;
         update(16'd9);
         check("invalid_no_beat", n_beats, nb0);
      end

      // Update while disabled, then issue when enable comes back.
      @(negedge aclk);
      enable = 1'b0;
      repeat (2) @(negedge aclk);
      update(16'd5);
      model_drain();
      @(negedge aclk);
      enable = 1'b1;
      wait_done(100);

      // 16-bit index wrap.
      set_qsize(32768);
      update(16'd32773);
      update(16'd65534);
      set_qsize(256);
      update(16'd2);

      // Back-pressure with clear held until the handshake.
      set_qsize(16);
      rdy_mode = 2;
      repeat (2) @(negedge aclk);
      exp_q.push_back({1'b0, 16'd2, 16'd2});
      send_update(16'd12);
      wait_tvalid("stall_tvalid_seen");
      for (int i = 0; i < 5; i++) begin
         check("stall_tvalid", tx_if.tvalid, 1);
         check("stall_tdata", tx_if.tdata, {16'd2, 16'd2});
         check("stall_tlast", tx_if.tlast, 0);
         if (i == 2) clear = 1'b1;
         if (i == 3) clear = 1'b0;
         @(negedge aclk);
      end
      check("clear_held_last", dbg_last, 16'd2);
      check("clear_held_target", dbg_target, 16'd12);
      m_last   = 16'd0;
      m_target = 16'd0;
      rdy_mode = 0;
      wait_done(100);
      repeat (5) @(negedge aclk);
      check("clear_after_last", dbg_last, 16'd0);

      // Asynchronous reset in the middle of a stalled burst.
      rdy_mode = 2;
      repeat (2) @(negedge aclk);
      send_update(16'd8);
      wait_tvalid("arst_tvalid_seen");
      #2;
      areset = 1'b1;
      #1;
      check("arst_tvalid", tx_if.tvalid, 0);
      check("arst_state", dbg_state, IDLE);
      check("arst_last", dbg_last, 0);
      check("arst_target", dbg_target, 0);
      check("arst_rx_ready", rx_if.tready, 1);
      m_last   = 16'd0;
      m_target = 16'd0;
      repeat (2) @(negedge aclk);
      areset   = 1'b0;
      rdy_mode = 0;
      repeat (2) @(negedge aclk);

      // Randomized updates, queue sizes, clears and back-pressure.
      for (int it = 0; it < 150; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0)      set_qsize(1 << $urandom_range(0, 6));
         else if (r == 1) pulse_clear();
         rdy_mode = $urandom_range(0, 1);
         update(m_last + 16'($urandom_range(0, m_q + 1)));
      end
      rdy_mode = 0;
      repeat (4) @(negedge aclk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
